// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: handshake and control bundle between the RV32I sequencer and the datapath
//   inputs to sequencer : start, opcode, funct3, branch_taken, imem_ready, dmem_ready
//   outputs of sequencer: imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, rf_we, wb_sel,
//                         pc_we, pc_sel, retired, halted, illegal, timeout, state
interface mc_control_fsm_if #(parameter int RET_W = 32);
  logic             start;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             alu_src_imm;
  logic             rf_we;
  logic [2:0]       wb_sel;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic [RET_W-1:0] retired;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [2:0]       state;
  modport master (
    input  start, opcode, funct3, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, rf_we, wb_sel,
           pc_we, pc_sel, retired, halted, illegal, timeout, state
  );
  modport slave (
    output start, opcode, funct3, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, rf_we, wb_sel,
           pc_we, pc_sel, retired, halted, illegal, timeout, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb, faults, retire count)
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : mc_control_fsm_if master (decoder fields, memory readies in; control strobes out)
module mc_control_fsm #(
  parameter int RET_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              i_clock,
  input logic              i_reset_n,
  mc_control_fsm_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_wait;
  logic [RET_W-1:0] r_retired;
  logic             r_halted, r_illegal, r_timeout;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_op, w_ecall, w_legal;
  logic w_wait_st, w_ready, w_tmo, w_retire;
  assign w_lui   = bus.opcode == 7'b0110111;
  assign w_auipc = bus.opcode == 7'b0010111;
  assign w_jal   = bus.opcode == 7'b1101111;
  assign w_jalr  = bus.opcode == 7'b1100111;
  assign w_br    = bus.opcode == 7'b1100011;
  assign w_ld    = bus.opcode == 7'b0000011;
  assign w_st    = bus.opcode == 7'b0100011;
  assign w_opi   = bus.opcode == 7'b0010011;
  assign w_op    = bus.opcode == 7'b0110011;
  assign w_ecall = bus.opcode == 7'b1110011;
  // branch funct3 010/011 are unused encodings; JALR only defines funct3 000
  assign w_legal = (w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_opi | w_op) &&
                   !(w_br && bus.funct3[2:1] == 2'b01) && !(w_jalr && bus.funct3 != 3'b000);
  assign w_wait_st = r_state == FETCH || r_state == MEM;
  assign w_ready   = r_state == FETCH ? bus.imem_ready : bus.dmem_ready;
  // a ready arriving on the cycle the count hits the limit still wins
  assign w_tmo     = w_wait_st && !w_ready && r_wait == CW'(MEM_TIMEOUT);
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    bus.imem_req    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.alu_src_imm = 1'b0;
    bus.rf_we       = 1'b0;
    bus.wb_sel      = 3'd0;
    bus.pc_we       = 1'b0;
    bus.pc_sel      = 2'd0;
    case (r_state)
      IDLE:   w_next = bus.start ? FETCH : IDLE;
      FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_load  = bus.imem_ready;
        w_next       = bus.imem_ready ? DECODE : w_tmo ? FAULT : FETCH;
      end
      DECODE: w_next = w_ecall ? HALT : !w_legal ? FAULT : EXEC;
      EXEC: begin
        bus.alu_src_imm = w_opi | w_ld | w_st | w_jalr;
        bus.pc_we       = w_br;
        bus.pc_sel      = (w_br && bus.branch_taken) ? 2'd1 : 2'd0;
        w_retire        = w_br;
        w_next          = w_br ? FETCH : (w_ld | w_st) ? MEM : WB;
      end
      MEM: begin
        bus.dmem_req    = 1'b1;
        bus.alu_src_imm = 1'b1;
        bus.dmem_we     = w_st;
        bus.pc_we       = w_st && bus.dmem_ready;
        w_retire        = w_st && bus.dmem_ready;
        w_next          = bus.dmem_ready ? (w_st ? FETCH : WB) : w_tmo ? FAULT : MEM;
      end
      WB: begin
        bus.rf_we  = 1'b1;
        bus.pc_we  = 1'b1;
        w_retire   = 1'b1;
        bus.wb_sel = w_lui ? 3'd3 : w_auipc ? 3'd4 : (w_jal | w_jalr) ? 3'd2 : w_ld ? 3'd1 : 3'd0;
        bus.pc_sel = w_jal ? 2'd1 : w_jalr ? 2'd2 : 2'd0;
        w_next     = FETCH;
      end
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (w_wait_st && !w_ready && w_next == r_state) ? r_wait + CW'(1) : '0;
      r_retired <= r_retired + RET_W'(w_retire);
      r_halted  <= r_halted | (w_next == HALT);
      r_illegal <= r_illegal | (r_state == DECODE && w_next == FAULT);
      r_timeout <= r_timeout | w_tmo;
    end
  end
  assign bus.retired = r_retired;
  assign bus.halted  = r_halted;
  assign bus.illegal = r_illegal;
  assign bus.timeout = r_timeout;
  assign bus.state   = r_state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: table-driven scoreboard bench for the multi-cycle sequencer
module tb_mc_control_fsm;
  localparam int RW = 4;
  localparam int MT = 15;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd3, S_MEM = 3'd4;
  localparam logic [2:0] S_HALT = 3'd6, S_FAULT = 3'd7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mc_control_fsm_if #(.RET_W(RW)) bus ();
  mc_control_fsm #(.RET_W(RW), .MEM_TIMEOUT(MT)) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic tk; int iw; int dw;
    int lat; int fin; int ret; int rf; int wb; int pcw; int pcs; int imm; int dwe; int mreq;
    int ill; int tmo; int hlt;
  } vec_t;
  vec_t vecs[19];
  vec_t exp_q[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int fc, dc, lat, rf, wb, pcw, pcs, imm, dwe, mreq;
    bit left, done;
    string tag;
    fc = 0; dc = 0; lat = 0; rf = 0; wb = 0; pcw = 0; pcs = 0; imm = 0; dwe = 0; mreq = 0;
    left = 0; done = 0;
    do_reset();
    bus.opcode = v.op; bus.funct3 = v.f3; bus.branch_taken = v.tk;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    exp_q.push_back(v);
    pulse_start();
    for (int c = 0; c < 100 && !done; c++) begin
      bus.imem_ready = fc >= v.iw;
      bus.dmem_ready = dc >= v.dw;
      #1;
      lat++;
      if (bus.state == S_FETCH) fc++;
      if (bus.state == S_MEM) dc++;
      if (bus.state != S_FETCH) left = 1;
      if (bus.rf_we) begin rf = 1; wb = int'(bus.wb_sel); end
      if (bus.pc_we) begin pcw = 1; pcs = int'(bus.pc_sel); end
      if (bus.state == S_EXEC) imm = int'(bus.alu_src_imm);
      if (bus.dmem_we) dwe = 1;
      if (bus.dmem_req) mreq++;
      @(negedge clk);
      if ((left && bus.state == S_FETCH) || bus.state == S_HALT || bus.state == S_FAULT) done = 1;
    end
    #1;
    e = exp_q.pop_front();
    tag = $sformatf("v%0d", idx);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " end_state"}, 32'(bus.state), e.fin);
    chk({tag, " retired"}, 32'(bus.retired), e.ret);
    chk({tag, " rf_we"}, rf, e.rf);
    chk({tag, " wb_sel"}, wb, e.wb);
    chk({tag, " pc_we"}, pcw, e.pcw);
    chk({tag, " pc_sel"}, pcs, e.pcs);
    chk({tag, " alu_src_imm"}, imm, e.imm);
    chk({tag, " dmem_we"}, dwe, e.dwe);
    chk({tag, " dmem_req_cycles"}, mreq, e.mreq);
    chk({tag, " illegal"}, 32'(bus.illegal), e.ill);
    chk({tag, " timeout"}, 32'(bus.timeout), e.tmo);
    chk({tag, " halted"}, 32'(bus.halted), e.hlt);
    chk({tag, " req_at_end"}, 32'(bus.imem_req | bus.dmem_req), 32'(e.fin == 1));
  endtask
  initial begin
    //           op          f3  tk iw  dw  lat fin ret rf wb pcw pcs imm dwe mreq ill tmo hlt
    vecs[0]  = '{7'b0010011, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{7'b0110111, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{7'b0010111, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{7'b1101111, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{7'b1100111, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 2, 1, 2, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{7'b0000011, 3'd2, 1'b0, 0, 0, 5, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
    vecs[7]  = '{7'b0100011, 3'd2, 1'b0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0};
    vecs[8]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{7'b1100011, 3'd1, 1'b0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{7'b1100011, 3'd2, 1'b1, 0, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{7'b1100111, 3'd1, 1'b0, 0, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[12] = '{7'b0000000, 3'd0, 1'b0, 0, 0, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{7'b1110011, 3'd0, 1'b0, 0, 0, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{7'b0110011, 3'd0, 1'b0, 2, 0, 6, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{7'b0000011, 3'd2, 1'b0, 0, 3, 8, 1, 1, 1, 1, 1, 0, 1, 0, 4, 0, 0, 0};
    vecs[16] = '{7'b0010011, 3'd0, 1'b0, 15, 0, 19, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[17] = '{7'b0010011, 3'd0, 1'b0, 16, 0, 16, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[18] = '{7'b0100011, 3'd2, 1'b0, 0, 16, 19, 7, 0, 0, 0, 0, 0, 1, 1, 16, 0, 1, 0};
    bus.start = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    do_reset();
    #1;
    chk("reset state", 32'(bus.state), S_IDLE);
    chk("reset retired", 32'(bus.retired), 0);
    chk("reset flags", {bus.halted, bus.illegal, bus.timeout}, 0);
    chk("reset strobes", {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.alu_src_imm,
                          bus.rf_we, bus.wb_sel, bus.pc_we, bus.pc_sel}, 0);
    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);
    // ECALL halt is terminal and ignores start
    do_reset();
    bus.opcode = 7'b1110011; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    #1;
    chk("halt state", 32'(bus.state), S_HALT);
    chk("halt retired", 32'(bus.retired), 0);
    pulse_start();
    repeat (2) @(negedge clk);
    #1;
    chk("halt after start", 32'(bus.state), S_HALT);
    chk("halt sticky", 32'(bus.halted), 1);
    // async reset in the middle of a stalled store
    do_reset();
    bus.opcode = 7'b0010011;
    pulse_start();
    repeat (4) @(negedge clk);
    bus.opcode = 7'b0100011; bus.dmem_ready = 1'b0;
    #1;
    chk("pre-store retired", 32'(bus.retired), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("store in mem", {bus.state, bus.dmem_req, bus.dmem_we}, {S_MEM, 2'b11});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst dmem", {bus.dmem_req, bus.dmem_we}, 0);
    chk("async rst state", 32'(bus.state), S_IDLE);
    chk("async rst retired", 32'(bus.retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // retired counter wraps modulo 2^RW over back-to-back ALU instructions
    bus.opcode = 7'b0010011; bus.dmem_ready = 1'b1;
    pulse_start();
    repeat (60) @(negedge clk);
    #1;
    chk("retired at 15", 32'(bus.retired), 15);
    repeat (8) @(negedge clk);
    #1;
    chk("retired wrap", 32'(bus.retired), 1);
    chk("wrap state", 32'(bus.state), S_FETCH);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It drives fetch, decode, execute, memory and writeback using the opcode/funct3 fields produced by the instruction decoder. It issues the instruction-register load, memory requests, register-file write, PC update and writeback select. It also detects illegal instructions, memory timeouts and ECALL halt, and counts retired instructions.

Parameters:
RET_W, 32, width of retired-instruction counter (wraps modulo 2^RET_W)
MEM_TIMEOUT, 15, max cycles a memory request may wait for ready before FAULT (>=1)

Ports:
clock  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
opcode  in  7  decoded opcode (from IR, stable DECODE..final state)
funct3  in  3  decoded funct3
branch_taken  in  1  ALU branch compare result, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
alu_src_imm  out  1  ALU operand B = imm
rf_we  out  1  register file write enable
wb_sel  out  3  0 ALU, 1 mem data, 2 PC+4, 3 imm, 4 PC+imm
pc_we  out  1  PC update enable
pc_sel  out  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1
retired  out  RET_W  retired instruction count
halted  out  1  ECALL halt, sticky
illegal  out  1  illegal instruction fault, sticky
timeout  out  1  memory timeout fault, sticky
state  out  3  current state (debug)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (async, reset_n=0): state=IDLE, retired=0, wait counter=0, halted/illegal/timeout=0, all other outputs 0, applied immediately, including mid-operation.
- State, counter and sticky flags are registered. Other outputs are combinational from state, opcode, funct3 and the ready/branch inputs. All outputs are 0 unless stated.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1. When imem_ready=1: ir_load=1 the same cycle, -> DECODE.
- DECODE, one cycle, classifies the instruction:
  - opcode 1110011 -> HALT.
  - Opcodes not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> FAULT with illegal=1.
  - Branch with funct3 010/011, or JALR with funct3!=000 -> FAULT with illegal=1.
  - Otherwise -> EXEC.
- EXEC, one cycle. alu_src_imm=1 for 0010011, 0000011, 0100011, 1100111.
  - Branch: pc_we=1, pc_sel = branch_taken ? 1 : 0, retire, -> FETCH.
  - Load/store -> MEM.
  - All others -> WB.
- MEM: dmem_req=1, alu_src_imm=1, dmem_we=1 for store; held until dmem_ready=1.
  - Load -> WB.
  - Store: pc_we=1, pc_sel=0, retire on the ready cycle, -> FETCH.
- WB, one cycle: rf_we=1, pc_we=1, retire, -> FETCH.
  - wb_sel: LUI=3, AUIPC=4, JAL/JALR=2, load=1, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
- Retire: retired increments on each retiring cycle. Wraps from all-ones to 0. ECALL and faulting instructions do not retire.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on handshake.
  - Increments each FETCH/MEM cycle with ready=0.
  - When it reaches MEM_TIMEOUT with ready still 0: -> FAULT, timeout=1. Requests drop the following cycle.
  - Ready on the same cycle the count reaches MEM_TIMEOUT counts as success.
- HALT: halted=1. FAULT: illegal/timeout held. Both are terminal until reset; start is ignored.
- start is ignored outside IDLE.
- Zero-wait latency: ALU/LUI/JAL = 4 cycles, load = 5, store = 4, branch = 3.

Test Plan:
- Reset, start=1, opcode 0010011, imem/dmem ready tied 1 -> state 1,2,3,5,1; WB cycle has rf_we=1, wb_sel=0, pc_sel=0; EXEC has alu_src_imm=1; retired=1.
- Opcode 0000011, dmem_ready asserted 3 cycles after MEM entry -> dmem_req=1 for 4 cycles, dmem_we=0, then WB with wb_sel=1, retired+1.
- Opcode 1100011, funct3 000, branch_taken=1 -> EXEC pc_we=1, pc_sel=1, rf_we=0, next state FETCH; with funct3 010 -> FAULT, illegal=1.
- Opcode 1110011 -> HALT, halted=1, retired unchanged; pulsing start leaves state=6.
- MEM_TIMEOUT=15, imem_ready held 0 -> FETCH for 16 cycles, then FAULT with timeout=1, imem_req=0.
- reset_n low mid-MEM store -> dmem_req/dmem_we drop to 0 without a clock edge; state=0, retired=0.
